// File: rtl/sim_console.sv
// Memory-mapped console: TX FIFO feeding an 8N1 UART transmitter, plus sticky
// riscv-tests style tohost pass/fail latch.
module sim_console #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_o,
    output logic        test_done_o,
    output logic        test_pass_o,
    output logic [30:0] test_code_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level;
    logic          full, empty, ovf;

    tx_state_t   state, state_n;
    logic [15:0] div_cnt, div_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  shreg, sh_n;
    logic        tx_reg, tx_n;
    logic        pop, tick;

    logic        wr_en, rd_en, push_req, push_ok, stat_rd;
    logic [1:0]  word;
    logic [31:0] status;
    logic        unused_addr;

    assign unused_addr = ^addr_i[1:0];
    assign word     = addr_i[3:2];
    assign wr_en    = req_i & we_i;
    assign rd_en    = req_i & ~we_i;
    assign stat_rd  = rd_en && (word == 2'd1);
    assign push_req = wr_en && (word == 2'd0);
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && (!full || pop);
    assign full     = (level == LW'(FIFO_DEPTH));
    assign empty    = (level == '0);
    assign status   = {20'b0, 4'(level), 4'b0, ovf, (state != IDLE), empty, full};

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop);
            // Read-to-clear loses against a drop in the same cycle.
            ovf   <= (ovf & ~stat_rd) | (push_req & ~push_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= stat_rd ? status : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            test_done_o <= 1'b0;
            test_pass_o <= 1'b0;
            test_code_o <= '0;
        end else if (wr_en && (word == 2'd2) && wdata_i[0] && !test_done_o) begin
            test_done_o <= 1'b1;
            test_pass_o <= (wdata_i == 32'd1);
            test_code_o <= wdata_i[31:1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_reg  <= 1'b1;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_idx <= bit_n;
            shreg   <= sh_n;
            tx_reg  <= tx_n;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_idx;
        sh_n    = shreg;
        tx_n    = tx_reg;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rd_ptr];
                    tx_n    = 1'b0;
                    div_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    div_n   = '0;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end else begin
                    div_n = div_cnt + 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    div_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n = bit_idx + 3'd1;
                        sh_n  = shreg >> 1;
                        tx_n  = shreg[1];
                    end
                end else begin
                    div_n = div_cnt + 16'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx_o = tx_reg;

endmodule
